control_sequencer: RTL and testbench

//  Hardwired control unit directly upstream of datapath: generates every datapath control strobe.
//  One-hot step FSM (T0..T6) runs fetch (T0-T2), then decodes IR for execute.

---
 rtl/control_sequencer_pkg.sv | 67 ++++++
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer_reg_select_encode.sv | 41 ++++
 rtl/control_sequencer.sv | 155 +++++++++++++++
 tb/tb_control_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: IR layout, opcodes,
// step-state encoding and the opcode-to-ALU-operation mapping.
package control_sequencer_pkg;

    localparam int NREGS       = 16;
    localparam int OPW         = 5;
    localparam int REG_FIELD_W = 4;

    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;

    localparam logic [OPW-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPW-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPW-1:0] OPC_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OPC_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OPC_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OPC_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OPC_HALT = 5'b11011;

    // The datapath ALU uses a different code for NOT than the instruction set.
    localparam logic [OPW-1:0] ALU_NOT = 5'b00010;

    typedef enum logic [8:0] {
        S_RST = 9'b0_0000_0001,
        T0    = 9'b0_0000_0010,
        T1    = 9'b0_0000_0100,
        T2    = 9'b0_0000_1000,
        T3    = 9'b0_0001_0000,
        T4    = 9'b0_0010_0000,
        T5    = 9'b0_0100_0000,
        T6    = 9'b0_1000_0000,
        HALT  = 9'b1_0000_0000
    } state_t;

    typedef enum logic [2:0] {
        CLS_RFMT,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } ins_class_t;

    function automatic ins_class_t decode_class(input logic [OPW-1:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL: return CLS_RFMT;
            OPC_NEG, OPC_NOT: return CLS_UNARY;
            OPC_MUL, OPC_DIV: return CLS_MULDIV;
            OPC_NOP:          return CLS_NOP;
            OPC_HALT:         return CLS_HALT;
            default:          return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [OPW-1:0] alu_op(input logic [OPW-1:0] opc);
        if (opc == OPC_NOT) return ALU_NOT;
        return opc;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [31:0]      ir;
    logic             stop;
    logic [NREGS-1:0] rin;
    logic [NREGS-1:0] rout;
    logic             pc_in;
    logic             pc_out;
    logic             ir_in;
    logic             mar_in;
    logic             mdr_in;
    logic             mdr_out;
    logic             read;
    logic             inc_pc;
    logic             y_in;
    logic             z_high_in;
    logic             z_low_in;
    logic             z_high_out;
    logic             z_low_out;
    logic             hi_in;
    logic             lo_in;
    logic [OPW-1:0]   op;
    logic             run;
    logic             illegal;

    modport master (
        input  ir, stop,
        output rin, rout, pc_in, pc_out, ir_in, mar_in, mdr_in, mdr_out, read, inc_pc,
               y_in, z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in, op, run, illegal
    );

    modport slave (
        output ir, stop,
        input  rin, rout, pc_in, pc_out, ir_in, mar_in, mdr_in, mdr_out, read, inc_pc,
               y_in, z_high_in, z_low_in, z_high_out, z_low_out, hi_in, lo_in, op, run, illegal
    );

endinterface

// File: rtl/control_sequencer_reg_select_encode.sv
// Picks the Ra/Rb/Rc field of IR and turns it into one-hot register
// write-enable and bus-drive vectors. Purely combinational.
module control_sequencer_reg_select_encode
    import control_sequencer_pkg::*;
(
    input  logic [31:0]      ir,
    input  logic             gra,
    input  logic             grb,
    input  logic             grc,
    input  logic             rin_en,
    input  logic             rout_en,
    output logic [NREGS-1:0] rin,
    output logic [NREGS-1:0] rout
);

    logic [REG_FIELD_W-1:0] field;
    logic [NREGS-1:0]       onehot;
    logic                   unused_ir;

    assign unused_ir = ^{ir[31:27], ir[14:0]};

    always_comb begin
        field  = '0;
        onehot = '0;
        if (gra) begin
            field = ir[IR_RA_LSB +: REG_FIELD_W];
        end else if (grb) begin
            field = ir[IR_RB_LSB +: REG_FIELD_W];
        end else if (grc) begin
            field = ir[IR_RC_LSB +: REG_FIELD_W];
        end
        // No field selected means no register touches the bus at all.
        if (gra || grb || grc) begin
            onehot[field] = 1'b1;
        end
    end

    assign rin  = rin_en  ? onehot : '0;
    assign rout = rout_en ? onehot : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired step sequencer: fetch in T0-T2, then opcode-driven execute steps.
// All strobes are Moore outputs decoded from the one-hot step state and IR.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    state_t     state;
    state_t     state_next;
    state_t     last_next;
    ins_class_t cls;
    logic [OPW-1:0] opc;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin_en;
    logic       rout_en;

    assign opc       = bus.ir[IR_OPC_LSB +: OPW];
    assign cls       = decode_class(opc);
    assign last_next = bus.stop ? HALT : T0;
    assign bus.run   = (state != S_RST) && (state != HALT);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.pc_in      = 1'b0;
        bus.pc_out     = 1'b0;
        bus.ir_in      = 1'b0;
        bus.mar_in     = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.read       = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_high_in  = 1'b0;
        bus.z_low_in   = 1'b0;
        bus.z_high_out = 1'b0;
        bus.z_low_out  = 1'b0;
        bus.hi_in      = 1'b0;
        bus.lo_in      = 1'b0;
        bus.op         = '0;
        bus.illegal    = 1'b0;
        gra            = 1'b0;
        grb            = 1'b0;
        grc            = 1'b0;
        rin_en         = 1'b0;
        rout_en        = 1'b0;

        case (state)
            S_RST: state_next = T0;
            T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                state_next = T1;
            end
            T1: begin
                bus.pc_in  = 1'b1;
                bus.read   = 1'b1;
                bus.mdr_in = 1'b1;
                state_next = T2;
            end
            T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
                state_next  = (cls == CLS_NOP) ? last_next : T3;
            end
            T3: begin
                case (cls)
                    CLS_RFMT: begin
                        grb = 1'b1; rout_en = 1'b1; bus.y_in = 1'b1;
                        state_next = T4;
                    end
                    CLS_UNARY: begin
                        grb = 1'b1; rout_en = 1'b1;
                        bus.op = alu_op(opc); bus.z_low_in = 1'b1;
                        state_next = T4;
                    end
                    CLS_MULDIV: begin
                        gra = 1'b1; rout_en = 1'b1; bus.y_in = 1'b1;
                        state_next = T4;
                    end
                    CLS_HALT:    state_next = HALT;
                    CLS_ILLEGAL: begin
                        bus.illegal = 1'b1;
                        state_next  = last_next;
                    end
                    default:     state_next = last_next;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_RFMT: begin
                        grc = 1'b1; rout_en = 1'b1;
                        bus.op = alu_op(opc); bus.z_low_in = 1'b1;
                        state_next = T5;
                    end
                    CLS_UNARY: begin
                        bus.z_low_out = 1'b1; gra = 1'b1; rin_en = 1'b1;
                        state_next = last_next;
                    end
                    CLS_MULDIV: begin
                        grb = 1'b1; rout_en = 1'b1; bus.op = alu_op(opc);
                        bus.z_high_in = 1'b1; bus.z_low_in = 1'b1;
                        state_next = T5;
                    end
                    default: state_next = T0;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_RFMT: begin
                        bus.z_low_out = 1'b1; gra = 1'b1; rin_en = 1'b1;
                        state_next = last_next;
                    end
                    CLS_MULDIV: begin
                        bus.z_low_out = 1'b1; bus.lo_in = 1'b1;
                        state_next = T6;
                    end
                    default: state_next = T0;
                endcase
            end
            T6: begin
                bus.z_high_out = 1'b1;
                bus.hi_in      = 1'b1;
                state_next     = last_next;
            end
            HALT:    state_next = HALT;
            default: state_next = S_RST;
        endcase
    end

    control_sequencer_reg_select_encode u_reg_select (
        .ir      (bus.ir),
        .gra     (gra),
        .grb     (grb),
        .grc     (grc),
        .rin_en  (rin_en),
        .rout_en (rout_en),
        .rin     (bus.rin),
        .rout    (bus.rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions plus a random stream,
// each checked cycle by cycle against a per-instruction micro-step list.
module tb_control_sequencer;

    typedef struct packed {
        logic [16:0] fl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
    } step_t;

    localparam logic [16:0] F_PC_IN   = 17'h00001;
    localparam logic [16:0] F_PC_OUT  = 17'h00002;
    localparam logic [16:0] F_IR_IN   = 17'h00004;
    localparam logic [16:0] F_MAR_IN  = 17'h00008;
    localparam logic [16:0] F_MDR_IN  = 17'h00010;
    localparam logic [16:0] F_MDR_OUT = 17'h00020;
    localparam logic [16:0] F_READ    = 17'h00040;
    localparam logic [16:0] F_INC_PC  = 17'h00080;
    localparam logic [16:0] F_Y_IN    = 17'h00100;
    localparam logic [16:0] F_ZH_IN   = 17'h00200;
    localparam logic [16:0] F_ZL_IN   = 17'h00400;
    localparam logic [16:0] F_ZH_OUT  = 17'h00800;
    localparam logic [16:0] F_ZL_OUT  = 17'h01000;
    localparam logic [16:0] F_HI_IN   = 17'h02000;
    localparam logic [16:0] F_LO_IN   = 17'h04000;
    localparam logic [16:0] F_RUN     = 17'h08000;
    localparam logic [16:0] F_ILL     = 17'h10000;

    logic clock;
    logic clear;
    int   checks;
    int   errors;
    step_t exp_q[$];
    logic [4:0] legal_ops [12];

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic step_t observe();
        step_t s;
        s.fl   = {bus.illegal, bus.run, bus.lo_in, bus.hi_in, bus.z_low_out, bus.z_high_out,
                  bus.z_low_in, bus.z_high_in, bus.y_in, bus.inc_pc, bus.read, bus.mdr_out,
                  bus.mdr_in, bus.mar_in, bus.ir_in, bus.pc_out, bus.pc_in};
        s.rin  = bus.rin;
        s.rout = bus.rout;
        s.op   = bus.op;
        return s;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'd1 << n;
    endfunction

    function automatic void push(input logic [16:0] fl, input logic [15:0] rin,
                                 input logic [15:0] rout, input logic [4:0] op);
        step_t s;
        s.fl = fl | F_RUN; s.rin = rin; s.rout = rout; s.op = op;
        exp_q.push_back(s);
    endfunction

    // Micro-step list for one instruction; returns 1 if it is HALT.
    function automatic bit build_model(input logic [31:0] ir);
        logic [4:0] o;
        logic [3:0] ra, rb, rc;
        o = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        exp_q.delete();
        push(F_PC_OUT | F_MAR_IN | F_INC_PC, 16'h0, 16'h0, 5'd0);
        push(F_PC_IN | F_READ | F_MDR_IN, 16'h0, 16'h0, 5'd0);
        push(F_MDR_OUT | F_IR_IN, 16'h0, 16'h0, 5'd0);
        if (o >= 5'd3 && o <= 5'd8) begin
            push(F_Y_IN, 16'h0, oh(rb), 5'd0);
            push(F_ZL_IN, 16'h0, oh(rc), o);
            push(F_ZL_OUT, oh(ra), 16'h0, 5'd0);
        end else if (o == 5'd17 || o == 5'd18) begin
            push(F_ZL_IN, 16'h0, oh(rb), (o == 5'd18) ? 5'd2 : o);
            push(F_ZL_OUT, oh(ra), 16'h0, 5'd0);
        end else if (o == 5'd15 || o == 5'd16) begin
            push(F_Y_IN, 16'h0, oh(ra), 5'd0);
            push(F_ZH_IN | F_ZL_IN, 16'h0, oh(rb), o);
            push(F_ZL_OUT | F_LO_IN, 16'h0, 16'h0, 5'd0);
            push(F_ZH_OUT | F_HI_IN, 16'h0, 16'h0, 5'd0);
        end else if (o == 5'd27) begin
            push(17'h0, 16'h0, 16'h0, 5'd0);
            return 1'b1;
        end else if (o != 5'd26) begin
            push(F_ILL, 16'h0, 16'h0, 5'd0);
        end
        return 1'b0;
    endfunction

    task automatic apply_reset(input string tag);
        step_t obs;
        clear = 1'b0;
        bus.stop = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s_assert: got %h want 0", tag, obs);
        end
        repeat (2) @(negedge clock);
        obs = observe();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s_held: got %h want 0", tag, obs);
        end
        clear = 1'b1;
    endtask

    // Runs one instruction from T0. stop is high during step stop_pulse and,
    // if stop_last, during the final step. abort_step >= 0 pulls Clear there.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int stop_pulse,
                             input bit stop_last, input int abort_step, output bit halted);
        bit    is_halt;
        int    n;
        step_t obs;
        is_halt = build_model(ir);
        n = exp_q.size();
        halted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s step%0d ir=%h: got %h want %h", tag, i, ir, obs, exp_q[i]);
            end
            if (i == 0) bus.ir = ir;
            if (i == abort_step) begin
                apply_reset({tag, "_abort"});
                return;
            end
            bus.stop = (i == n - 1) ? stop_last : (i == stop_pulse);
        end
        halted = is_halt || stop_last;
        if (halted) begin
            @(negedge clock);
            bus.stop = 1'b0;
            obs = observe();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL %s_halt ir=%h: got %h want 0", tag, ir, obs);
            end
        end
    endtask

    task automatic test_reset();
        bit h;
        clear = 1'b1;
        bus.ir = '0;
        bus.stop = 1'b0;
        #2;
        apply_reset("por");
        run_instr("add_abort", 32'h191A0000, -1, 1'b0, 4, h);
    endtask

    task automatic test_not();
        bit h;
        run_instr("not", 32'h90080000, -1, 1'b0, -1, h);
    endtask

    task automatic test_add();
        bit h;
        run_instr("add", 32'h191A0000, -1, 1'b0, -1, h);
        run_instr("add_pulse", 32'h191A0000, 3, 1'b0, -1, h);
    endtask

    task automatic test_mul();
        bit h;
        run_instr("mul", 32'h7AB00000, -1, 1'b0, -1, h);
    endtask

    task automatic test_nop_halt();
        bit h;
        step_t obs;
        run_instr("nop", 32'hD0000000, -1, 1'b0, -1, h);
        run_instr("halt", 32'hD8000000, -1, 1'b0, -1, h);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            obs = observe();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL halt_sticky cyc%0d: got %h want 0", i, obs);
            end
        end
        apply_reset("after_halt");
    endtask

    task automatic test_stop_illegal();
        bit h;
        run_instr("not_stop", 32'h90080000, -1, 1'b1, -1, h);
        apply_reset("after_stop");
        run_instr("illegal", 32'hF8000000, -1, 1'b0, -1, h);
        run_instr("after_illegal", 32'h20A18000, -1, 1'b0, -1, h);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] o;
        bit legal;
        o = legal_ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 7) == 0) begin
            for (int t = 0; t < 32; t++) begin
                o = 5'($urandom);
                legal = 1'b0;
                foreach (legal_ops[k]) if (legal_ops[k] == o) legal = 1'b1;
                if (!legal) break;
            end
        end
        return {o, 27'($urandom)};
    endfunction

    task automatic test_back_to_back();
        bit h;
        bit sl;
        int sp;
        for (int i = 0; i < 80; i++) begin
            sl = ($urandom_range(0, 11) == 0);
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
            run_instr("rand", rand_ir(), sp, sl, -1, h);
            if (h) apply_reset("rand_rst");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
        test_reset();
        test_not();
        test_add();
        test_mul();
        test_nop_halt();
        test_stop_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
